// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// default geometry and the byte-counter width helper.
package imem_loader_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;
  localparam int BYTES_PER_WORD = DEF_DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    CKSUM = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  // Width of a counter that indexes the bytes of one data_w-bit word.
  function automatic int bcnt_width(input int data_w);
    return (data_w / 8 > 1) ? $clog2(data_w / 8) : 1;
  endfunction

  localparam int BCNT_W = bcnt_width(DEF_DATA_W);

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles accepted bytes little-endian into a word and pulses word_valid
// the cycle after the last byte of a word arrives.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              take,
  input  logic [7:0]        byte_data,
  output logic              completing,
  output logic              word_valid,
  output logic [DATA_W-1:0] word
);

  localparam int BPW = DATA_W / 8;
  localparam int BW  = bcnt_width(DATA_W);

  logic [BW-1:0]     bcnt;
  logic [DATA_W-1:0] asm_q;
  logic [DATA_W-1:0] merged;

  // Byte k of a word lands in bits [8k+7:8k]; the finished word is
  // copied to word so the write data stays stable while the next fills.
  always_comb begin
    merged = asm_q;
    merged[int'(bcnt) * 8 +: 8] = byte_data;
  end

  assign completing = take && (bcnt == BW'(BPW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt       <= '0;
      asm_q      <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= completing;
      if (clear) begin
        bcnt <= '0;
      end else if (take) begin
        asm_q <= merged;
        bcnt  <= completing ? '0 : bcnt + 1'b1;
      end
      if (completing) word <= merged;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a header-prefixed byte stream into imem and holds the CPU in reset
// meanwhile. Define IMEM_LOADER_CKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_data,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output state_t            dbg_state
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] last_idx;
  logic [ADDR_W:0]   wcnt;
  logic              start_ok, take, pk_take, completing, word_valid;
  logic              last_word_taken;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]        cksum;
`endif

  // Handshake: a byte moves on a rising edge where byte_valid and byte_ready
  // are both high; a byte offered alongside abort is not taken.
  assign start_ok        = start && (state inside {IDLE, DONE, ERR});
  assign take            = byte_valid && byte_ready && !abort;
  assign pk_take         = take && (state == DATA);
  assign last_word_taken = completing && (wcnt == {1'b0, last_idx});
  assign dbg_state       = state;

  imem_loader_byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_ok),
    .take       (pk_take),
    .byte_data  (byte_data),
    .completing (completing),
    .word_valid (word_valid),
    .word       (im_data)
  );

  assign im_we = word_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_nxt = HDR;
      HDR: begin
        if (abort)     state_nxt = ERR;
        else if (take) state_nxt = DATA;
      end
      // The last word's write cycle is spent in DATA with byte_ready low.
      DATA: begin
        if (abort) state_nxt = ERR;
        else if (word_valid && (im_addr == last_idx)) begin
`ifdef IMEM_LOADER_CKSUM_EN
          state_nxt = CKSUM;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CKSUM_EN
      CKSUM: begin
        if (abort)     state_nxt = ERR;
        else if (take) state_nxt = (byte_data == cksum) ? DONE : ERR;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_rst_n  <= 1'b1;
      im_addr    <= '0;
      last_idx   <= '0;
      wcnt       <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum      <= '0;
`endif
    end else begin
      state      <= state_nxt;
      byte_ready <= (state_nxt inside {HDR, DATA, CKSUM}) && !(pk_take && last_word_taken);
      busy       <= state_nxt inside {HDR, DATA, CKSUM};
      done       <= (state_nxt == DONE);
      err        <= (state_nxt == ERR);
      cpu_rst_n  <= state_nxt inside {IDLE, DONE};
      if (start_ok) wcnt <= '0;
      if (take && (state == HDR)) last_idx <= ADDR_W'(byte_data);
      if (completing) begin
        im_addr <= wcnt[ADDR_W-1:0];
        wcnt    <= wcnt + 1'b1;
      end
`ifdef IMEM_LOADER_CKSUM_EN
      if (take && (state == HDR)) cksum <= byte_data;
      if (pk_take)                cksum <= cksum ^ byte_data;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset values, normal and gappy loads,
// abort, asynchronous reset mid-load, full 256-word load, checksum option.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n, start, abort, byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready, im_we, cpu_rst_n, busy, done, err;
  logic [ADDR_W-1:0] im_addr;
  logic [DATA_W-1:0] im_data;
  state_t            dbg_state;

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_data    (im_data),
    .cpu_rst_n  (cpu_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int writes = 0;
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [7:0]        stim_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_addr_q.push_back(a);
    exp_q.push_back(d);
  endtask

  // Scoreboard: every write must match the head of the expected queue, and
  // the CPU must be held in reset whenever a load is in progress.
  always @(negedge clk) begin
    if (rst_n && busy) chk("cpu_rst_busy", 32'(cpu_rst_n), 32'd0);
    if (rst_n && im_we) begin
      writes++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write addr %h data %h expected none", im_addr, im_data);
      end
      if (exp_q.size() != 0) begin
        chk("im_addr", 32'(im_addr), 32'(exp_addr_q.pop_front()));
        chk("im_data", im_data, exp_q.pop_front());
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_im_we"},      32'(im_we),      32'd0);
    chk({tag, "_im_addr"},    32'(im_addr),    32'd0);
    chk({tag, "_im_data"},    im_data,         32'd0);
    chk({tag, "_cpu_rst_n"},  32'(cpu_rst_n),  32'd1);
    chk({tag, "_busy"},       32'(busy),       32'd0);
    chk({tag, "_done"},       32'(done),       32'd0);
    chk({tag, "_err"},        32'(err),        32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("send_ready", 32'(byte_ready), 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

`ifdef IMEM_LOADER_CKSUM_EN
  function automatic logic [7:0] stim_xor(input logic [7:0] n);
    logic [7:0] x = n;
    foreach (stim_q[i]) x ^= stim_q[i];
    return x;
  endfunction
`endif

  task automatic send_load(input logic [7:0] n, input bit gappy);
    send_byte(n);
    for (int i = 0; i < stim_q.size(); i++) begin
      send_byte(stim_q[i]);
      if (gappy) begin
        if (i == 4) repeat (5) @(negedge clk);
        else if (i % 2 == 0) @(negedge clk);
      end
    end
`ifdef IMEM_LOADER_CKSUM_EN
    send_byte(stim_xor(n));
`endif
  endtask

  task automatic wait_end(input logic exp_done);
    int t = 0;
    while (!(done || err) && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("end_done", 32'(done), 32'(exp_done));
    chk("end_err",  32'(err),  32'(!exp_done));
  endtask

  initial begin
    int w0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic two-word load.
    pulse_start();
    chk("start_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_byte_ready", 32'(byte_ready), 32'd1);
    push_exp(8'd0, 32'h4433_2211);
    push_exp(8'd1, 32'h8877_6655);
    stim_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_load(8'h01, 1'b0);
    wait_end(1'b1);
    chk("load1_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    chk("load1_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("hold_addr", 32'(im_addr), 32'd1);
    chk("hold_data", im_data, 32'h8877_6655);
    chk("load1_pending", 32'(exp_q.size()), 32'd0);

    // Same load with a stuttering source.
    pulse_start();
    push_exp(8'd0, 32'h4433_2211);
    push_exp(8'd1, 32'h8877_6655);
    send_load(8'h01, 1'b1);
    wait_end(1'b1);
    chk("gappy_pending", 32'(exp_q.size()), 32'd0);

    // Abort after six data bytes of a four-word load.
    pulse_start();
    push_exp(8'd0, 32'hA3A2_A1A0);
    send_byte(8'h03);
    for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_err", 32'(err), 32'd1);
    chk("abort_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_byte_ready", 32'(byte_ready), 32'd0);
    w0 = writes;
    repeat (6) @(negedge clk);
    chk("abort_no_writes", 32'(writes - w0), 32'd0);
    chk("abort_pending", 32'(exp_q.size()), 32'd0);
    chk("abort_err_hold", 32'(err), 32'd1);

    // Restart from ERR.
    pulse_start();
    chk("reload_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    push_exp(8'd0, 32'hEFBE_ADDE);
    stim_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_load(8'h00, 1'b0);
    wait_end(1'b1);
    chk("reload_data", im_data, 32'hEFBE_ADDE);

    // Asynchronous reset in the middle of DATA.
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h55);
    send_byte(8'h66);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("postreset");

    // Full 256-word load; the word counter must stop at 0xFF.
    pulse_start();
    stim_q.delete();
    for (int w = 0; w < 256; w++) begin
      for (int j = 0; j < 4; j++) stim_q.push_back(8'(w) ^ {2'(j), 6'b0});
      push_exp(8'(w), {8'(w) ^ 8'hC0, 8'(w) ^ 8'h80, 8'(w) ^ 8'h40, 8'(w)});
    end
    w0 = writes;
    send_load(8'hFF, 1'b0);
    wait_end(1'b1);
    chk("full_writes", 32'(writes - w0), 32'd256);
    chk("full_last_addr", 32'(im_addr), 32'hFF);
    chk("full_pending", 32'(exp_q.size()), 32'd0);

`ifdef IMEM_LOADER_CKSUM_EN
    // Checksum accepted, then rejected; the word is written in both cases.
    pulse_start();
    push_exp(8'd0, 32'h0804_0201);
    send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
    send_byte(8'h0F);
    wait_end(1'b1);
    pulse_start();
    push_exp(8'd0, 32'h0804_0201);
    send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
    send_byte(8'h0E);
    wait_end(1'b0);
    chk("cksum_bad_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("cksum_pending", 32'(exp_q.size()), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface; the CPU core is the reader.
- Accepts a byte stream (valid/ready), assembles DATA_W-bit instruction words little-endian and writes them to sequential imem addresses from 0.
- Holds the CPU core in reset while loading and releases it when the load completes.
- Sits between the host byte source (UART receiver or testbench) and the imem write port.

Parameters:
ADDR_W, 8, imem address width; matches the 8-bit PC.
DATA_W, 32, instruction width; must be a multiple of 8.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
abort  in  1  cancels a load in progress.
byte_valid  in  1  byte_data holds a valid byte.
byte_data  in  8  stream byte.
byte_ready  out  1  loader can accept a byte.
im_we  out  1  imem write strobe; one-cycle pulse.
im_addr  out  ADDR_W  imem write address.
im_data  out  DATA_W  imem write data.
cpu_rst_n  out  1  active-low reset to the CPU core.
busy  out  1  high in HDR, DATA or CKSUM.
done  out  1  high in DONE.
err  out  1  high in ERR.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, byte_ready=0, im_we=0, im_addr=0, im_data=0, cpu_rst_n=1, busy=0, done=0, err=0, byte counter=0, word counter=0.
- Handshake: a byte transfers only in a cycle with byte_valid&byte_ready. byte_ready is registered and high only in HDR, DATA and CKSUM.
- States:
  - IDLE: on start, go to HDR.
  - DONE or ERR: on start, go to HDR.
  - HDR: first byte accepted = N (last word index). N+1 words follow (1..2^ADDR_W). Go to DATA.
  - DATA: byte k of each word goes to bits [8k+7:8k]; k=0 arrives first.
  - After DATA_W/8 bytes, im_we pulses on the next cycle with im_addr=word index and im_data=assembled word.
  - Word index runs 0..N. After the write of word N, go to CKSUM (feature on) or DONE.
  - Byte acceptance continues without stalling during the im_we cycle.
- cpu_rst_n: 0 in HDR, DATA, CKSUM and ERR; 1 in IDLE and DONE. It goes low the cycle after start is sampled.
- abort in HDR, DATA or CKSUM: go to ERR next cycle. A pending im_we for a completed word still issues; no further writes.
- start while busy is ignored. abort outside busy states is ignored. Simultaneous start and abort in IDLE/DONE/ERR: start wins.
- Word counter never wraps: N=255 ends at address 255.
- im_addr and im_data hold their last values when im_we=0.
- Reset mid-load: immediate return to reset values. imem contents are untouched and the CPU is released.

Optional Feature:
- Macro: IMEM_LOADER_CKSUM_EN.
- With the macro: after the last data byte, state CKSUM accepts one byte. The expected value is the XOR of the header byte and all data bytes. Match goes to DONE; mismatch goes to ERR. Already-written words remain in imem.
- Without the macro: no CKSUM state; DATA goes directly to DONE after the last write.

Decomposition:
- Shared package imem_loader_pkg holds: the state encoding (IDLE, HDR, DATA, CKSUM, DONE, ERR); BYTES_PER_WORD=DATA_W/8; the byte-counter width.
- One natural sub-module: byte_packer. It performs shift-in assembly of bytes into a word and raises a word_valid pulse. The FSM stays in imem_loader.

Test Plan:
- Reset, then start with N=0x01 and bytes 11 22 33 44 55 66 77 88 -> im_we at addr 0 data 0x44332211, addr 1 data 0x88776655; done=1; cpu_rst_n low from the cycle after start until DONE.
- Same load with byte_valid toggled every other cycle and one 5-cycle gap -> identical writes; no byte lost or duplicated.
- abort after 6 data bytes of an N=3 load -> word 0 written, then ERR; err=1; cpu_rst_n=0; no further im_we. A subsequent start reloads successfully.
- rst_n asserted in DATA -> all outputs at reset values immediately (asynchronously); cpu_rst_n=1.
- N=0xFF with 1024 data bytes -> 256 writes, last at addr 0xFF; no wrap; DONE.
- With IMEM_LOADER_CKSUM_EN, N=0 and bytes 01 02 04 08: checksum 0x0F -> DONE; checksum 0x0E -> ERR, word 0x08040201 still written.
